bp_update_ctrl: RTL and testbench

- Sequencer for the 2-bit branch predictor table; sits between fetch, branch resolution (EX/MEM), and the table's read and write ports.
- Buffers resolved-branch outcomes in an in-order queue and drains one table update per cycle.
- Runs a whole-table reinitialisation sweep on flush request; gates predictions to not-taken/invalid while the sweep runs.

---
 rtl/bp_update_ctrl.sv | 180 ++++++++++++++++++
 tb/tb_bp_update_ctrl.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/bp_update_ctrl.sv
// bp_update_ctrl
// Sequencer for the 2-bit branch predictor table. It sits between fetch,
// branch resolution and the table's read and write ports:
//   - resolved branches are queued in order and drained one table update
//     per cycle
//   - a flush request starts a sweep that reinitialises every table entry;
//     predictions are gated to invalid/not-taken while the sweep runs
//
// Optional feature: define BP_UPDATE_STATS_EN to build the drained-update
// and mispredict counters. Without it, stat_* are tied to 0 and no counter
// flops are built.
//
// Ports:
//   clk, rst            clock, asynchronous active-high reset
//   res_*               resolved-branch input with valid/ready handshake
//   flush_req           one-cycle pulse that starts a table reinit sweep
//   pred_read_en/idx    prediction request from fetch
//   tbl_read/ridx       table read port
//   tbl_pred            table prediction (combinational from tbl_ridx)
//   pred_valid/taken    prediction returned to fetch
//   tbl_write/widx/
//     wtaken/init       table write port; init forces the entry to 2'b01
//   busy                sweep in progress
//   stat_branches/
//     stat_mispred      saturating statistics (optional)
//
// state | meaning
// ------+--------------------------------------------------------------
// RUN   | accept resolved branches, drain one update per cycle, predict
// SWEEP | write 2'b01 to every table entry; no predictions or pushes
module bp_update_ctrl #(
    parameter int IDX_W = 10,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             res_valid,
    input  logic [IDX_W-1:0] res_idx,
    input  logic             res_taken,
    input  logic             res_predicted,
    output logic             res_ready,
    input  logic             flush_req,
    input  logic             pred_read_en,
    input  logic [IDX_W-1:0] pred_idx,
    output logic             tbl_read,
    output logic [IDX_W-1:0] tbl_ridx,
    input  logic             tbl_pred,
    output logic             pred_valid,
    output logic             pred_taken,
    output logic             tbl_write,
    output logic [IDX_W-1:0] tbl_widx,
    output logic             tbl_wtaken,
    output logic             tbl_init,
    output logic             busy,
    output logic [31:0]      stat_branches,
    output logic [31:0]      stat_mispred
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    typedef enum logic {RUN, SWEEP} state_t;

    state_t           state;
    logic             active;     // low during reset and its release cycle
    logic [IDX_W-1:0] sweep_cnt;

    logic [IDX_W-1:0] q_idx   [DEPTH];
    logic             q_taken [DEPTH];
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] wr_ptr;
    logic [CNT_W-1:0] count;

    logic run;
    logic full;
    logic empty;
    logic push;
    logic pop;
    logic run_flush;

    assign run       = active && (state == RUN);
    assign full      = (count == CNT_W'(DEPTH));
    assign empty     = (count == '0);
    assign run_flush = run && flush_req;
    assign res_ready = run && !full;
    // A flush discards both the queue and any same-cycle transfer, so the
    // head is neither written nor popped in the flush cycle.
    assign push      = res_valid && res_ready && !flush_req;
    assign pop       = run && !empty && !flush_req;

    assign busy       = (state == SWEEP);
    assign tbl_read   = run && pred_read_en;
    assign tbl_ridx   = tbl_read ? pred_idx : '0;
    assign pred_valid = tbl_read;
    assign pred_taken = tbl_read && tbl_pred;
    assign tbl_write  = busy || pop;
    assign tbl_init   = busy;
    assign tbl_widx   = busy ? sweep_cnt : (pop ? q_idx[rd_ptr] : '0);
    assign tbl_wtaken = pop && q_taken[rd_ptr];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= RUN;
            active    <= 1'b0;
            sweep_cnt <= '0;
        end else begin
            active <= 1'b1;
            case (state)
                RUN: begin
                    if (run_flush) begin
                        state     <= SWEEP;
                        sweep_cnt <= '0;
                    end
                end
                SWEEP: begin
                    if (flush_req) begin
                        sweep_cnt <= '0;
                    end else if (sweep_cnt == {IDX_W{1'b1}}) begin
                        state     <= RUN;
                        sweep_cnt <= '0;
                    end else begin
                        sweep_cnt <= sweep_cnt + IDX_W'(1);
                    end
                end
                default: state <= RUN;
            endcase
        end
    end

    // Queue storage needs no reset: occupancy decides what is valid.
    always_ff @(posedge clk) begin
        if (push) begin
            q_idx[wr_ptr]   <= res_idx;
            q_taken[wr_ptr] <= res_taken;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else if (run_flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            if (push && !pop)      count <= count + CNT_W'(1);
            else if (pop && !push) count <= count - CNT_W'(1);
        end
    end

`ifdef BP_UPDATE_STATS_EN
    logic q_pred [DEPTH];

    always_ff @(posedge clk) begin
        if (push) q_pred[wr_ptr] <= res_predicted;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stat_branches <= '0;
            stat_mispred  <= '0;
        end else if (pop) begin
            if (stat_branches != 32'hFFFF_FFFF)
                stat_branches <= stat_branches + 32'd1;
            if ((q_taken[rd_ptr] != q_pred[rd_ptr]) && (stat_mispred != 32'hFFFF_FFFF))
                stat_mispred <= stat_mispred + 32'd1;
        end
    end
`else
    logic unused_res_predicted;
    assign unused_res_predicted = res_predicted;
    assign stat_branches = '0;
    assign stat_mispred  = '0;
`endif

endmodule

// File: tb/tb_bp_update_ctrl.sv
module tb_bp_update_ctrl;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        res_valid = 1'b0;
    logic [9:0]  res_idx = '0;
    logic        res_taken = 1'b0;
    logic        res_predicted = 1'b0;
    logic        res_ready;
    logic        flush_req = 1'b0;
    logic        pred_read_en = 1'b1;
    logic [9:0]  pred_idx = 10'h3FF;
    logic        tbl_read;
    logic [9:0]  tbl_ridx;
    logic        tbl_pred;
    logic        pred_valid;
    logic        pred_taken;
    logic        tbl_write;
    logic [9:0]  tbl_widx;
    logic        tbl_wtaken;
    logic        tbl_init;
    logic        busy;
    logic [31:0] stat_branches;
    logic [31:0] stat_mispred;

    bp_update_ctrl #(.IDX_W(10), .DEPTH(4)) dut (
        .clk(clk), .rst(rst),
        .res_valid(res_valid), .res_idx(res_idx), .res_taken(res_taken),
        .res_predicted(res_predicted), .res_ready(res_ready),
        .flush_req(flush_req),
        .pred_read_en(pred_read_en), .pred_idx(pred_idx),
        .tbl_read(tbl_read), .tbl_ridx(tbl_ridx), .tbl_pred(tbl_pred),
        .pred_valid(pred_valid), .pred_taken(pred_taken),
        .tbl_write(tbl_write), .tbl_widx(tbl_widx), .tbl_wtaken(tbl_wtaken),
        .tbl_init(tbl_init), .busy(busy),
        .stat_branches(stat_branches), .stat_mispred(stat_mispred)
    );

    always #5 clk = ~clk;

    // 2-bit saturating counter table driven by the DUT's write port.
    logic [1:0] tbl [0:1023];
    assign tbl_pred = tbl[tbl_ridx][1];

    always @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 1024; i++) tbl[i] <= 2'b01;
        end else if (tbl_write) begin
            if (tbl_init)                                 tbl[tbl_widx] <= 2'b01;
            else if (tbl_wtaken && tbl[tbl_widx] != 2'b11)  tbl[tbl_widx] <= tbl[tbl_widx] + 2'b01;
            else if (!tbl_wtaken && tbl[tbl_widx] != 2'b00) tbl[tbl_widx] <= tbl[tbl_widx] - 2'b01;
        end
    end

    typedef struct packed {
        logic [9:0] idx;
        logic       taken;
        logic       pred;
    } upd_t;

    upd_t sb[$];
    int   tests = 0;
    int   fails = 0;
    int   exp_br = 0;
    int   exp_mis = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp)
        else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Every non-init table write must match the oldest accepted entry.
    always @(negedge clk) begin
        upd_t e;
        if (!rst && tbl_write && !tbl_init) begin
            if (sb.size() == 0) begin
                check("unexpected_write_idx", 32'(tbl_widx), 32'hFFFF_FFFF);
            end else begin
                e = sb.pop_front();
                check("drain_idx", 32'(tbl_widx), 32'(e.idx));
                check("drain_taken", 32'(tbl_wtaken), 32'(e.taken));
                exp_br++;
                if (e.taken != e.pred) exp_mis++;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [9:0] idx, input logic tk, input logic pr);
        res_valid = 1'b1;
        res_idx = idx;
        res_taken = tk;
        res_predicted = pr;
        #1;
        check("res_ready_push", 32'(res_ready), 32'd1);
        if (res_ready) sb.push_back('{idx: idx, taken: tk, pred: pr});
        @(posedge clk);
        #1;
        res_valid = 1'b0;
    endtask

    task automatic wait_drain();
        for (int c = 0; c < 20 && sb.size() != 0; c++) tick();
        check("drain_done_sb_left", 32'(sb.size()), 32'd0);
    endtask

    task automatic check_stats(input string tag);
`ifdef BP_UPDATE_STATS_EN
        check({tag, "_branches"}, stat_branches, 32'(exp_br));
        check({tag, "_mispred"}, stat_mispred, 32'(exp_mis));
`else
        check({tag, "_branches"}, stat_branches, 32'd0);
        check({tag, "_mispred"}, stat_mispred, 32'd0);
`endif
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_res_ready", 32'(res_ready), 32'd0);
        check("rst_outputs", 32'({tbl_write, busy, tbl_read, pred_valid, pred_taken, tbl_init}), 32'd0);
        check_stats("rst");
        tick();
        rst = 1'b0;
        tick();
        @(negedge clk);
        check("ready_after_release", 32'(res_ready), 32'd1);
        check("pred_valid_run", 32'(pred_valid), 32'd1);
        check("pred_3ff_initial", 32'(pred_taken), 32'd0);

        // single entry: written the cycle after acceptance
        tick();
        push(10'h005, 1'b1, 1'b0);
        check("lat_write", 32'({tbl_write, tbl_init, tbl_wtaken}), 32'b101);
        check("lat_widx", 32'(tbl_widx), 32'h005);
        tick();
        check_stats("first");

        // burst of five: order preserved, never backpressured
        for (int k = 0; k < 5; k++)
            push(10'(k * 16 + 3), k[0], k[1]);
        wait_drain();

        // same index three times: each update sees the previous one
        push(10'h3FF, 1'b1, 1'b1);
        push(10'h3FF, 1'b1, 1'b1);
        push(10'h3FF, 1'b1, 1'b1);
        wait_drain();
        @(negedge clk);
        check("tbl_3ff_sat", 32'(tbl[10'h3FF]), 32'b11);
        check("pred_3ff_taken", 32'({pred_valid, pred_taken}), 32'b11);
        check_stats("after_3ff");

        // flush with an entry at the head plus a same-cycle transfer
        tick();
        res_valid = 1'b1; res_idx = 10'h007; res_taken = 1'b1; res_predicted = 1'b1;
        tick();
        res_idx = 10'h008;
        flush_req = 1'b1;
        #1;
        check("flush_cycle_no_write", 32'(tbl_write), 32'd0);
        tick();
        res_valid = 1'b0;
        flush_req = 1'b0;
        for (int i = 0; i < 1024; i++) begin
            @(negedge clk);
            check("sweep1", 32'({busy, tbl_write, tbl_init, tbl_wtaken, pred_valid, tbl_read, res_ready, tbl_widx}),
                  32'({7'b1110000, 10'(i)}));
            @(posedge clk);
        end
        @(negedge clk);
        check("sweep1_done", 32'({busy, tbl_write, res_ready, pred_valid}), 32'b0011);
        check("tbl_3ff_reinit", 32'(tbl[10'h3FF]), 32'b01);
        check("pred_3ff_after_sweep", 32'(pred_taken), 32'd0);

        // flush again at index 500: restart from 0, full 1024 cycles after
        tick();
        flush_req = 1'b1;
        tick();
        flush_req = 1'b0;
        for (int i = 0; i <= 500; i++) begin
            @(negedge clk);
            check("sweep2_idx", 32'(tbl_widx), 32'(i));
            @(posedge clk);
            #1;
            flush_req = (i == 499);
        end
        for (int j = 0; j < 1024; j++) begin
            @(negedge clk);
            check("sweep2_restart", 32'({busy, tbl_init, tbl_widx}), 32'({2'b11, 10'(j)}));
            @(posedge clk);
        end
        @(negedge clk);
        check("sweep2_done", 32'({busy, res_ready}), 32'b01);

        // reset at sweep index 200
        tick();
        flush_req = 1'b1;
        tick();
        flush_req = 1'b0;
        repeat (200) @(posedge clk);
        #1;
        check("sweep3_at_200", 32'({busy, tbl_widx}), 32'({1'b1, 10'd200}));
        rst = 1'b1;
        exp_br = 0;
        exp_mis = 0;
        #1;
        check("rst_mid_sweep", 32'({tbl_write, busy, res_ready, pred_valid}), 32'd0);
        check_stats("rst_mid");
        tick();
        rst = 1'b0;
        tick();
        @(negedge clk);
        check("run_after_rst", 32'({res_ready, busy, tbl_write}), 32'b100);

        tick();
        push(10'h00B, 1'b0, 1'b1);
        wait_drain();
        tick();
        check_stats("final");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
